// File: rtl/riscv_pkg.sv
// Shared definitions for the RV64 pipeline front end.
//   ADDR_W_DEF / INST_W_DEF : default address and instruction widths
//   HALT_INST               : encoding that stops fetch (ecall)
//   fetch_state_e           : fetch FSM states
package riscv_pkg;

  localparam int unsigned ADDR_W_DEF = 64;
  localparam int unsigned INST_W_DEF = 32;

  localparam logic [31:0] HALT_INST = 32'h0000_0073;

  localparam logic [1:0] FETCH_BOOT   = 2'd0;
  localparam logic [1:0] FETCH_RUN    = 2'd1;
  localparam logic [1:0] FETCH_HALTED = 2'd2;

  typedef enum logic [1:0] {
    StBoot   = FETCH_BOOT,
    StRun    = FETCH_RUN,
    StHalted = FETCH_HALTED
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues combinational reads to instruction memory and
// registers the returned word into the IF/ID pipeline register.
// Ports:
//   i_clk, i_rst_n               clock (rising edge), async active-low reset
//   o_imem_valid, o_imem_addr    fetch request / byte address (= pc)
//   i_imem_valid, i_imem_inst    same-cycle memory response
//   i_stall                      hold pc and IF/ID
//   i_redirect, i_redirect_pc    flush and reload pc (taken branch/jump)
//   o_valid, o_pc, o_inst        IF/ID register contents
//   o_halted                     fetch has stopped
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int unsigned    ADDR_W    = ADDR_W_DEF,
  parameter int unsigned    INST_W    = INST_W_DEF,
  parameter int unsigned    MAX_INST  = 256,
  parameter logic [63:0]    RESET_PC  = 64'h0,
  parameter logic [31:0]    HALT_WORD = HALT_INST
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_imem_valid,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_valid,
  input  logic [INST_W-1:0] i_imem_inst,
  input  logic              i_stall,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_pc,
  output logic [INST_W-1:0] o_inst,
  output logic              o_halted
);

  // First byte address past the end of instruction memory.
  localparam logic [ADDR_W-1:0] PcLimit  = ADDR_W'(MAX_INST) << 2;
  localparam logic [ADDR_W-1:0] PcReset  = RESET_PC[ADDR_W-1:0];
  localparam logic [INST_W-1:0] HaltInst = INST_W'(HALT_WORD);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic [INST_W-1:0] inst_q, inst_d;

  logic              in_range;
  logic              req;
  logic [ADDR_W-1:0] redirect_aligned;

  // Redirect targets are word aligned; the low bits are dropped.
  logic [1:0] unused_redirect_lsb;
  assign unused_redirect_lsb = i_redirect_pc[1:0];
  assign redirect_aligned    = {i_redirect_pc[ADDR_W-1:2], 2'b00};

  assign in_range     = (pc_q < PcLimit);
  assign req          = (state_q == StRun) && in_range;
  assign o_imem_valid = req;
  assign o_imem_addr  = pc_q;

  assign o_valid  = valid_q;
  assign o_pc     = pc_out_q;
  assign o_inst   = inst_q;
  assign o_halted = (state_q == StHalted);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    pc_out_d = pc_out_q;
    inst_d   = inst_q;

    unique case (state_q)
      // One quiet cycle after reset; nothing is in flight, so stall/redirect are ignored.
      StBoot: begin
        state_d = StRun;
      end

      StRun: begin
        if (i_redirect) begin
          pc_d    = redirect_aligned;
          valid_d = 1'b0;
        end else if (i_stall) begin
          // hold everything
        end else if (req && i_imem_valid) begin
          pc_out_d = pc_q;
          inst_d   = i_imem_inst;
          valid_d  = 1'b1;
          if (i_imem_inst == HaltInst) begin
            state_d = StHalted;
          end else begin
            pc_d = pc_q + ADDR_W'(4);
          end
        end else begin
          valid_d = 1'b0;
          if (!in_range) begin
            state_d = StHalted;
          end
        end
      end

      StHalted: begin
        if (i_redirect) begin
          // The halt was speculative; a later-resolved redirect restarts fetch.
          pc_d    = redirect_aligned;
          valid_d = 1'b0;
          state_d = StRun;
        end else if (!i_stall) begin
          // Let the halt instruction drain downstream.
          valid_d = 1'b0;
        end
      end

      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StBoot;
      pc_q     <= PcReset;
      valid_q  <= 1'b0;
      pc_out_q <= '0;
      inst_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      pc_out_q <= pc_out_d;
      inst_q   <= inst_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural same-cycle memory holding
// 0x1000_0000+index, ecall at index 6. A second instance with MAX_INST=4 covers the
// end-of-memory halt.
module tb_instruction_fetch;

  localparam int unsigned AW = 64;
  localparam int unsigned IW = 32;

  logic          clk;
  logic          rst_n, rst_n2;
  logic          imem_req, imem_req2;
  logic [AW-1:0] imem_addr, imem_addr2;
  logic [IW-1:0] imem_inst, imem_inst2;
  logic          stall, redirect;
  logic [AW-1:0] redirect_pc;
  logic          valid, valid2;
  logic [AW-1:0] pc, pc2;
  logic [IW-1:0] inst, inst2;
  logic          halted, halted2;
  logic          zero;

  int n_vec;
  int n_miss;

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    logic [AW-1:0] idx;
    idx = a >> 2;
    if (idx == 6) return 32'h0000_0073;
    return 32'h1000_0000 + idx[31:0];
  endfunction

  always_comb imem_inst  = mem_word(imem_addr);
  always_comb imem_inst2 = mem_word(imem_addr2);

  instruction_fetch #(.MAX_INST(256)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imem_valid(imem_req), .o_imem_addr(imem_addr),
    .i_imem_valid(imem_req), .i_imem_inst(imem_inst),
    .i_stall(stall), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_valid(valid), .o_pc(pc), .o_inst(inst), .o_halted(halted)
  );

  instruction_fetch #(.MAX_INST(4)) dut_small (
    .i_clk(clk), .i_rst_n(rst_n2),
    .o_imem_valid(imem_req2), .o_imem_addr(imem_addr2),
    .i_imem_valid(imem_req2), .i_imem_inst(imem_inst2),
    .i_stall(zero), .i_redirect(zero), .i_redirect_pc('0),
    .o_valid(valid2), .o_pc(pc2), .o_inst(inst2), .o_halted(halted2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks IF/ID contents plus the current fetch address.
  task automatic chk_fetch(input string tag, input logic v, input logic [63:0] p,
                           input logic [31:0] w, input logic [63:0] a);
    check({tag, ".valid"}, 64'(valid), 64'(v));
    if (v) begin
      check({tag, ".pc"}, pc, p);
      check({tag, ".inst"}, 64'(inst), 64'(w));
    end
    check({tag, ".addr"}, imem_addr, a);
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    zero = 1'b0;
    rst_n = 1'b0; rst_n2 = 1'b0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

    // 1: reset and straight-line fetch
    #2;
    check("rst.valid", 64'(valid), 0);
    check("rst.pc", pc, 0);
    check("rst.inst", 64'(inst), 0);
    check("rst.halted", 64'(halted), 0);
    check("rst.req", 64'(imem_req), 0);
    tick(); tick();
    rst_n = 1'b1;
    check("boot.req", 64'(imem_req), 0);
    tick();
    check("run.req", 64'(imem_req), 1);
    chk_fetch("f0pre", 1'b0, 0, 0, 0);
    tick(); chk_fetch("f0", 1'b1, 0, 32'h1000_0000, 4);
    tick(); chk_fetch("f4", 1'b1, 4, 32'h1000_0001, 8);
    tick(); chk_fetch("f8", 1'b1, 8, 32'h1000_0002, 12);

    // 2: three stall cycles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_fetch("stall", 1'b1, 8, 32'h1000_0002, 12);
    end
    stall = 1'b0;
    tick(); chk_fetch("f12", 1'b1, 12, 32'h1000_0003, 16);
    tick(); chk_fetch("f16", 1'b1, 16, 32'h1000_0004, 20);

    // 3: redirect beats simultaneous stall, target misaligned
    redirect = 1'b1; redirect_pc = 64'h15; stall = 1'b1;
    tick();
    redirect = 1'b0; stall = 1'b0;
    check("redir.valid", 64'(valid), 0);
    check("redir.addr", imem_addr, 64'h14);
    tick(); chk_fetch("f20", 1'b1, 64'h14, 32'h1000_0005, 24);

    // 4: halt instruction at 24, then redirect out of HALTED
    tick(); chk_fetch("f24", 1'b1, 24, 32'h0000_0073, 24);
    tick();
    check("halt.valid", 64'(valid), 0);
    check("halt.halted", 64'(halted), 1);
    check("halt.req", 64'(imem_req), 0);
    tick();
    check("halt.hold", imem_addr, 24);
    redirect = 1'b1; redirect_pc = 64'h8;
    tick();
    redirect = 1'b0;
    check("resume.halted", 64'(halted), 0);
    check("resume.req", 64'(imem_req), 1);
    chk_fetch("resume", 1'b0, 0, 0, 8);
    tick(); chk_fetch("r8", 1'b1, 8, 32'h1000_0002, 12);
    tick(); chk_fetch("r12", 1'b1, 12, 32'h1000_0003, 16);

    // 6: asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.valid", 64'(valid), 0);
    check("arst.pc", pc, 0);
    check("arst.inst", 64'(inst), 0);
    check("arst.req", 64'(imem_req), 0);
    check("arst.addr", imem_addr, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rerun.req", 64'(imem_req), 1);
    tick(); chk_fetch("rerun0", 1'b1, 0, 32'h1000_0000, 4);

    // 5: MAX_INST=4 instance runs off the end of memory
    tick();
    rst_n2 = 1'b1;
    check("small.boot", 64'(imem_req2), 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("small.req", 64'(imem_req2), 1);
      check("small.addr", imem_addr2, 64'(4 * i));
      tick();
      check("small.valid", 64'(valid2), 1);
      check("small.pc", pc2, 64'(4 * i));
      check("small.inst", 64'(inst2), 64'(32'h1000_0000 + i));
    end
    check("small.end_req", 64'(imem_req2), 0);
    check("small.end_addr", imem_addr2, 16);
    check("small.not_yet", 64'(halted2), 0);
    tick();
    check("small.halted", 64'(halted2), 1);
    check("small.valid_off", 64'(valid2), 0);
    check("small.req_off", 64'(imem_req2), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
